// File: rtl/intr_ctrl_if.sv
// Signal bundle between the RAT control unit / Flags and the interrupt controller.
// The controller is the slave side; the control unit and bench drive the master side.
interface intr_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             intr_in;
  logic             i_set;
  logic             i_clr;
  logic             intr_ack;
  logic             reti_e;
  logic             reti_d;
  logic             intr_req;
  logic             i_out;
  logic             in_isr;
  logic             flg_shad_ld;
  logic             flg_ld_sel;
  logic [CNT_W-1:0] coal_cnt;

  modport master (
    output intr_in, i_set, i_clr, intr_ack, reti_e, reti_d,
    input  intr_req, i_out, in_isr, flg_shad_ld, flg_ld_sel, coal_cnt
  );

  modport slave (
    input  intr_in, i_set, i_clr, intr_ack, reti_e, reti_d,
    output intr_req, i_out, in_isr, flg_shad_ld, flg_ld_sel, coal_cnt
  );
endinterface

// File: rtl/intr_ctrl.sv
// RAT MCU interrupt controller: synchronises intr_in, holds one pending request,
// owns the I flag and steers the Flags shadow save/restore on ISR entry/exit.
module intr_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  intr_ctrl_if.slave ctrl_io
);

  typedef enum logic {
    IDLE = 1'b0,
    ISR  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_dly_q;
  logic                   sync_s;
  logic                   evt;
  logic                   intr_req;
  logic                   accept;
  logic                   ret;
  logic                   pend_q, pend_d;
  logic                   ien_q, ien_d;
  logic [CNT_W-1:0]       coal_q, coal_d;
  state_t                 state_q, state_d;

  assign sync_s = sync_q[SYNC_STAGES-1];
  // Level mode re-raises pending every cycle the synced input stays high.
  assign evt    = (EDGE_MODE != 0) ? (sync_s & ~sync_dly_q) : sync_s;

  assign intr_req = pend_q & ien_q & (state_q == IDLE);
  assign accept   = ctrl_io.intr_ack & intr_req;
  assign ret      = ctrl_io.reti_e | ctrl_io.reti_d;

  assign ctrl_io.intr_req    = intr_req;
  assign ctrl_io.i_out       = ien_q;
  assign ctrl_io.in_isr      = (state_q == ISR);
  assign ctrl_io.flg_shad_ld = accept;
  assign ctrl_io.flg_ld_sel  = (state_q == ISR) & ret;
  assign ctrl_io.coal_cnt    = coal_q;

  always_comb begin
    pend_d = pend_q;
    if (evt) begin
      pend_d = 1'b1;
    end else if (accept) begin
      pend_d = 1'b0;
    end

    coal_d = coal_q;
    if (evt && pend_q && !accept && (coal_q != {CNT_W{1'b1}})) begin
      coal_d = coal_q + 1'b1;
    end

    // Clearing sources outrank setting sources, so SEI+CLI and RETIE+RETID both leave I=0.
    ien_d = ien_q;
    if (accept || ctrl_io.reti_d || ctrl_io.i_clr) begin
      ien_d = 1'b0;
    end else if (ctrl_io.reti_e || ctrl_io.i_set) begin
      ien_d = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISR;
      ISR:     if (ret) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
      pend_q     <= 1'b0;
      ien_q      <= 1'b0;
      coal_q     <= '0;
      state_q    <= IDLE;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ctrl_io.intr_in};
      sync_dly_q <= sync_s;
      pend_q     <= pend_d;
      ien_q      <= ien_d;
      coal_q     <= coal_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Scenario bench for intr_ctrl: each task queues the output snapshot it expects,
// then pops and compares it against the live outputs at the sample point.
module tb_intr_ctrl;

  typedef struct {
    string      name;
    logic [8:0] val;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [8:0] obs;
  exp_t       exp_q[$];
  exp_t       e;
  int         total;
  int         bad;

  intr_ctrl_if #(.CNT_W(4)) bus ();

  intr_ctrl #(
    .SYNC_STAGES(2),
    .EDGE_MODE  (1),
    .CNT_W      (4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ctrl_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {intr_req, i_out, in_isr, flg_shad_ld, flg_ld_sel, coal_cnt}
  assign obs = {bus.intr_req, bus.i_out, bus.in_isr, bus.flg_shad_ld, bus.flg_ld_sel, bus.coal_cnt};

  function automatic logic [8:0] ev(input logic req, input logic i, input logic isr,
                                    input logic shad, input logic sel, input int cnt);
    logic [3:0] c;
    c = cnt[3:0];
    return {req, i, isr, shad, sel, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.intr_in  = 1'b0;
    bus.i_set    = 1'b0;
    bus.i_clr    = 1'b0;
    bus.intr_ack = 1'b0;
    bus.reti_e   = 1'b0;
    bus.reti_d   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_intr(input int hi, input int lo);
    bus.intr_in = 1'b1;
    repeat (hi) tick();
    bus.intr_in = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    bus.intr_in = 1'b1;
    bus.i_set   = 1'b1;
    exp_q.push_back('{name: "rst_held", val: ev(0, 0, 0, 0, 0, 0)});
    tick();
    tick();
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    bus.intr_in = 1'b0;
    bus.i_set   = 1'b0;
    tick();
    rst = 1'b0;
    exp_q.push_back('{name: "rst_release", val: ev(0, 0, 0, 0, 0, 0)});
    repeat (4) tick();
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
  endtask

  task automatic test_basic();
    do_reset();
    bus.i_set = 1'b1;
    tick();
    bus.i_set   = 1'b0;
    bus.intr_in = 1'b1;
    exp_q.push_back('{name: "lat_edge1", val: ev(0, 1, 0, 0, 0, 0)});
    exp_q.push_back('{name: "lat_edge2", val: ev(0, 1, 0, 0, 0, 0)});
    exp_q.push_back('{name: "lat_edge3", val: ev(1, 1, 0, 0, 0, 0)});
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      e = exp_q.pop_front(); total++;
      if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
      else $display("ok   %s %b", e.name, obs);
    end
    bus.intr_ack = 1'b1;
    exp_q.push_back('{name: "ack_shadow_ld", val: ev(1, 1, 0, 1, 0, 0)});
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    tick();
    bus.intr_ack = 1'b0;
    exp_q.push_back('{name: "enter_isr", val: ev(0, 0, 1, 0, 0, 0)});
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
  endtask

  task automatic test_return();
    bus.reti_e = 1'b1;
    exp_q.push_back('{name: "retie_ld_sel", val: ev(0, 0, 1, 0, 1, 0)});
    exp_q.push_back('{name: "retie_exit", val: ev(0, 1, 0, 0, 0, 0)});
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    tick();
    bus.reti_e = 1'b0;
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    bus.intr_in = 1'b0;
    repeat (3) tick();
    bus.intr_in = 1'b1;
    exp_q.push_back('{name: "reentry_req", val: ev(1, 1, 0, 0, 0, 0)});
    repeat (3) tick();
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    bus.intr_ack = 1'b1;
    tick();
    bus.intr_ack = 1'b0;
    bus.reti_d   = 1'b1;
    exp_q.push_back('{name: "retid_ld_sel", val: ev(0, 0, 1, 0, 1, 0)});
    exp_q.push_back('{name: "retid_exit", val: ev(0, 0, 0, 0, 0, 0)});
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    tick();
    bus.reti_d  = 1'b0;
    bus.intr_in = 1'b0;
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
  endtask

  task automatic test_masked();
    do_reset();
    exp_q.push_back('{name: "masked_noreq", val: ev(0, 0, 0, 0, 0, 0)});
    pulse_intr(3, 3);
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    bus.i_set = 1'b1;
    exp_q.push_back('{name: "unmask_req", val: ev(1, 1, 0, 0, 0, 0)});
    tick();
    bus.i_set = 1'b0;
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    bus.intr_ack = 1'b1;
    tick();
    bus.intr_ack = 1'b0;
    exp_q.push_back('{name: "isr_holds_new", val: ev(0, 0, 1, 0, 0, 0)});
    pulse_intr(3, 3);
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    bus.reti_e = 1'b1;
    exp_q.push_back('{name: "nested_after_reti", val: ev(1, 1, 0, 0, 0, 0)});
    tick();
    bus.reti_e = 1'b0;
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
  endtask

  task automatic test_coalesce();
    do_reset();
    exp_q.push_back('{name: "coal_three", val: ev(0, 0, 0, 0, 0, 2)});
    repeat (3) pulse_intr(3, 3);
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    exp_q.push_back('{name: "coal_reach_max", val: ev(0, 0, 0, 0, 0, 15)});
    repeat (13) pulse_intr(3, 3);
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    exp_q.push_back('{name: "coal_saturated", val: ev(0, 0, 0, 0, 0, 15)});
    repeat (7) pulse_intr(3, 3);
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    bus.i_set = 1'b1;
    tick();
    bus.i_set    = 1'b0;
    bus.intr_ack = 1'b1;
    tick();
    bus.intr_ack = 1'b0;
    bus.reti_e   = 1'b1;
    exp_q.push_back('{name: "coal_kept_after_isr", val: ev(0, 1, 0, 0, 0, 15)});
    tick();
    bus.reti_e = 1'b0;
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
  endtask

  task automatic test_corners();
    do_reset();
    bus.i_set = 1'b1;
    bus.i_clr = 1'b1;
    exp_q.push_back('{name: "set_clr_same", val: ev(0, 0, 0, 0, 0, 0)});
    tick();
    bus.i_set = 1'b0;
    bus.i_clr = 1'b0;
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    bus.i_set = 1'b1;
    tick();
    bus.i_set    = 1'b0;
    bus.intr_ack = 1'b1;
    exp_q.push_back('{name: "ack_no_req", val: ev(0, 1, 0, 0, 0, 0)});
    exp_q.push_back('{name: "ack_ignored", val: ev(0, 1, 0, 0, 0, 0)});
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    tick();
    bus.intr_ack = 1'b0;
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr  = 1'b0;
    bus.reti_e = 1'b1;
    exp_q.push_back('{name: "reti_idle_no_sel", val: ev(0, 0, 0, 0, 0, 0)});
    exp_q.push_back('{name: "reti_idle_sets_i", val: ev(0, 1, 0, 0, 0, 0)});
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    tick();
    bus.reti_e = 1'b0;
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    bus.reti_e = 1'b1;
    bus.reti_d = 1'b1;
    exp_q.push_back('{name: "reti_both_clear", val: ev(0, 0, 0, 0, 0, 0)});
    tick();
    bus.reti_e = 1'b0;
    bus.reti_d = 1'b0;
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    bus.i_set = 1'b1;
    tick();
    bus.i_set   = 1'b0;
    bus.intr_in = 1'b1;
    repeat (3) tick();
    bus.intr_ack = 1'b1;
    tick();
    bus.intr_ack = 1'b0;
    bus.intr_in  = 1'b0;
    exp_q.push_back('{name: "pre_rst_in_isr", val: ev(0, 0, 1, 0, 0, 0)});
    exp_q.push_back('{name: "rst_async_mid_isr", val: ev(0, 0, 0, 0, 0, 0)});
    exp_q.push_back('{name: "post_rst_idle", val: ev(0, 0, 0, 0, 0, 0)});
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    rst = 1'b1;
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
    tick();
    rst = 1'b0;
    tick();
    #1;
    e = exp_q.pop_front(); total++;
    if (obs !== e.val) begin bad++; $display("FAIL %s got=%b want=%b", e.name, obs, e.val); end
    else $display("ok   %s %b", e.name, obs);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_inputs();
    test_reset();
    test_basic();
    test_return();
    test_masked();
    test_coalesce();
    test_corners();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
